// File: rtl/tomasulo_fetch_issue.sv
// Tomasulo front end: 32x16 instruction store, one-entry fetch register and the issue stage.
// Issue allocates a ROB entry and an RS slot, reads rename tags for rs1/rs2 and renames rd.
module tomasulo_fetch_issue (
    input  logic        clk1,
    input  logic        rst,
    input  logic        prog_we,
    input  logic [4:0]  prog_addr,
    input  logic [15:0] prog_data,
    input  logic [4:0]  pc,
    input  logic        fetch_en,
    input  logic        commit,
    input  logic        rs_free,
    input  logic [1:0]  rs_free_unit,
    input  logic [1:0]  rs_free_slot,
    output logic [15:0] inst,
    output logic        issue_ok,
    output logic        stall,
    output logic [1:0]  issue_unit,
    output logic [1:0]  issue_slot,
    output logic [2:0]  issue_rob,
    output logic [3:0]  issue_rs1_tag,
    output logic [3:0]  issue_rs2_tag,
    output logic [3:0]  rob_count
);
    localparam logic [1:0] UnitAdd = 2'd0;
    localparam logic [1:0] UnitMul = 2'd1;
    localparam logic [1:0] UnitBr  = 2'd2;
    localparam logic [1:0] UnitLs  = 2'd3;

    logic [15:0] mem_q [32];
    logic        valid_q;
    logic [15:0] inst_q;
    logic [3:0]  rob_dest_q [8];
    logic [7:0]  rob_wr_q;
    logic [2:0]  head_q;
    logic [2:0]  tail_q;
    logic [3:0]  count_q;
    logic [3:0]  rs_busy_q [4];
    logic [15:0] ren_busy_q;
    logic [2:0]  ren_tag_q [16];

    logic [3:0] func;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [3:0] rd;
    logic       legal;
    logic       writes_rd;
    logic [1:0] unit;
    logic [1:0] slot;
    logic [3:0] free_vec;
    logic       slot_found;
    logic       commit_ok;
    logic [3:0] head_dest;
    logic [3:0] free_mask;

    // Slots that physically exist in each unit.
    function automatic logic [3:0] unit_mask(input logic [1:0] u);
        case (u)
            UnitAdd, UnitMul: unit_mask = 4'b0111;
            UnitBr:           unit_mask = 4'b0011;
            default:          unit_mask = 4'b1111;
        endcase
    endfunction

    always_comb begin
        func      = inst_q[15:12];
        rs1       = inst_q[11:8];
        rs2       = inst_q[7:4];
        rd        = inst_q[3:0];
        legal     = ~func[3];
        writes_rd = ~func[2] | (func[1:0] == 2'b00);
        unit      = UnitAdd;
        case (func[2:1])
            2'b00:   unit = UnitAdd;
            2'b01:   unit = UnitMul;
            2'b10:   unit = UnitLs;
            default: unit = UnitBr;
        endcase
        free_vec   = ~rs_busy_q[unit] & unit_mask(unit);
        slot_found = |free_vec;
        slot       = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (free_vec[i]) slot = 2'(i);
        end
        issue_ok  = valid_q & legal & ~count_q[3] & slot_found;
        stall     = valid_q & legal & ~issue_ok;
        commit_ok = commit & (count_q != 4'd0);
        head_dest = rob_dest_q[head_q];
        free_mask = unit_mask(rs_free_unit);

        inst          = inst_q;
        issue_unit    = unit;
        issue_slot    = slot;
        issue_rob     = tail_q;
        issue_rs1_tag = ren_busy_q[rs1] ? {1'b1, ren_tag_q[rs1]} : 4'd0;
        issue_rs2_tag = ren_busy_q[rs2] ? {1'b1, ren_tag_q[rs2]} : 4'd0;
        rob_count     = count_q;
    end

    always_ff @(posedge clk1) begin
        if (prog_we) mem_q[prog_addr] <= prog_data;
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            valid_q    <= 1'b0;
            inst_q     <= 16'd0;
            head_q     <= 3'd0;
            tail_q     <= 3'd0;
            count_q    <= 4'd0;
            ren_busy_q <= 16'd0;
            for (int u = 0; u < 4; u++) rs_busy_q[u] <= 4'd0;
        end else begin
            if (!stall) begin
                if (fetch_en) begin
                    inst_q  <= mem_q[pc];
                    valid_q <= 1'b1;
                end else begin
                    valid_q <= 1'b0;
                end
            end
            if (rs_free && free_mask[rs_free_slot]) rs_busy_q[rs_free_unit][rs_free_slot] <= 1'b0;
            if (issue_ok) rs_busy_q[unit][slot] <= 1'b1;
            if (commit_ok) begin
                // Only clear if no younger writer has re-renamed the register.
                if (rob_wr_q[head_q] && ren_busy_q[head_dest] && ren_tag_q[head_dest] == head_q)
                    ren_busy_q[head_dest] <= 1'b0;
                head_q <= head_q + 3'd1;
            end
            if (issue_ok) begin
                rob_dest_q[tail_q] <= rd;
                rob_wr_q[tail_q]   <= writes_rd;
                tail_q             <= tail_q + 3'd1;
                if (writes_rd) begin
                    ren_busy_q[rd] <= 1'b1;
                    ren_tag_q[rd]  <= tail_q;
                end
            end
            count_q <= count_q + {3'b000, issue_ok} - {3'b000, commit_ok};
        end
    end
endmodule

// File: tb/tb_tomasulo_fetch_issue.sv
// Self-checking bench for tomasulo_fetch_issue: directed scenarios plus random traffic
// compared against a queue-based behavioural model.
module tb_tomasulo_fetch_issue;
    logic        clk1 = 1'b0;
    logic        rst;
    logic        prog_we;
    logic [4:0]  prog_addr;
    logic [15:0] prog_data;
    logic [4:0]  pc;
    logic        fetch_en;
    logic        commit;
    logic        rs_free;
    logic [1:0]  rs_free_unit;
    logic [1:0]  rs_free_slot;
    logic [15:0] inst;
    logic        issue_ok;
    logic        stall;
    logic [1:0]  issue_unit;
    logic [1:0]  issue_slot;
    logic [2:0]  issue_rob;
    logic [3:0]  issue_rs1_tag;
    logic [3:0]  issue_rs2_tag;
    logic [3:0]  rob_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk1 = ~clk1;

    tomasulo_fetch_issue dut (
        .clk1(clk1), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .pc(pc), .fetch_en(fetch_en), .commit(commit),
        .rs_free(rs_free), .rs_free_unit(rs_free_unit), .rs_free_slot(rs_free_slot),
        .inst(inst), .issue_ok(issue_ok), .stall(stall), .issue_unit(issue_unit),
        .issue_slot(issue_slot), .issue_rob(issue_rob), .issue_rs1_tag(issue_rs1_tag),
        .issue_rs2_tag(issue_rs2_tag), .rob_count(rob_count)
    );

    typedef struct {
        int dest;
        bit wr;
        int idx;
    } rob_entry_t;

    bit [15:0]  m_mem [32];
    bit         m_valid;
    bit [15:0]  m_inst;
    rob_entry_t m_rob [$];
    int         m_alloc;
    bit         m_rbusy [16];
    int         m_rtag [16];
    bit         m_slot [4][4];

    function automatic int unit_size(int u);
        if (u == 2) return 2;
        if (u == 3) return 4;
        return 3;
    endfunction

    function automatic int unit_of(int f);
        if (f <= 1) return 0;
        if (f <= 3) return 1;
        if (f <= 5) return 3;
        return 2;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_eval(output bit ok, output bit st, output int u, output int s,
                              output int rob, output int t1, output int t2);
        int f;
        int r1;
        int r2;
        f  = int'(m_inst[15:12]);
        r1 = int'(m_inst[11:8]);
        r2 = int'(m_inst[7:4]);
        u  = unit_of(f);
        s  = -1;
        for (int i = 0; i < unit_size(u); i++)
            if (!m_slot[u][i] && s < 0) s = i;
        ok  = m_valid && f < 8 && m_rob.size() < 8 && s >= 0;
        st  = m_valid && f < 8 && !ok;
        rob = m_alloc % 8;
        t1  = m_rbusy[r1] ? 8 + m_rtag[r1] : 0;
        t2  = m_rbusy[r2] ? 8 + m_rtag[r2] : 0;
    endtask

    task automatic model_update(input bit we, input int addr, input bit [15:0] data,
                                input int pcv, input bit fen, input bit cm, input bit fr,
                                input int fu, input int fs);
        bit ok;
        bit st;
        int u;
        int s;
        int rob;
        int t1;
        int t2;
        int f;
        int rd;
        rob_entry_t e;
        model_eval(ok, st, u, s, rob, t1, t2);
        f  = int'(m_inst[15:12]);
        rd = int'(m_inst[3:0]);
        if (!st) begin
            if (fen) begin
                m_inst  = m_mem[pcv];
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end
        if (cm && m_rob.size() > 0) begin
            e = m_rob.pop_front();
            if (e.wr && m_rbusy[e.dest] && m_rtag[e.dest] == e.idx) m_rbusy[e.dest] = 1'b0;
        end
        if (fr && fs < unit_size(fu)) m_slot[fu][fs] = 1'b0;
        if (ok) begin
            m_slot[u][s] = 1'b1;
            e.dest = rd;
            e.wr   = (f <= 4);
            e.idx  = rob;
            m_rob.push_back(e);
            m_alloc++;
            if (e.wr) begin
                m_rbusy[rd] = 1'b1;
                m_rtag[rd]  = rob;
            end
        end
        if (we) m_mem[addr] = data;
    endtask

    task automatic check_outputs();
        bit ok;
        bit st;
        int u;
        int s;
        int rob;
        int t1;
        int t2;
        model_eval(ok, st, u, s, rob, t1, t2);
        check_eq("inst", inst, m_inst);
        check_eq("issue_ok", issue_ok, ok);
        check_eq("stall", stall, st);
        check_eq("rob_count", rob_count, m_rob.size());
        if (ok) begin
            check_eq("issue_unit", issue_unit, u);
            check_eq("issue_slot", issue_slot, s);
            check_eq("issue_rob", issue_rob, rob);
            check_eq("rs1_tag", issue_rs1_tag, t1);
            check_eq("rs2_tag", issue_rs2_tag, t2);
        end
    endtask

    task automatic cycle(input bit we, input int addr, input bit [15:0] data, input int pcv,
                         input bit fen, input bit cm, input bit fr, input int fu, input int fs);
        prog_we      = we;
        prog_addr    = 5'(addr);
        prog_data    = data;
        pc           = 5'(pcv);
        fetch_en     = fen;
        commit       = cm;
        rs_free      = fr;
        rs_free_unit = 2'(fu);
        rs_free_slot = 2'(fs);
        @(posedge clk1);
        model_update(we, addr, data, pcv, fen, cm, fr, fu, fs);
        @(negedge clk1);
        check_outputs();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        prog_we  = 1'b0;
        fetch_en = $urandom_range(1);
        commit   = $urandom_range(1);
        rs_free  = 1'b0;
        @(posedge clk1);
        m_valid = 1'b0;
        m_inst  = 16'd0;
        m_rob.delete();
        m_alloc = 0;
        for (int i = 0; i < 16; i++) m_rbusy[i] = 1'b0;
        for (int u = 0; u < 4; u++)
            for (int s = 0; s < 4; s++) m_slot[u][s] = 1'b0;
        @(negedge clk1);
        rst = 1'b0;
        check_eq("rst_inst", inst, 0);
        check_eq("rst_issue_ok", issue_ok, 0);
        check_eq("rst_stall", stall, 0);
        check_eq("rst_unit", issue_unit, 0);
        check_eq("rst_slot", issue_slot, 0);
        check_eq("rst_rob", issue_rob, 0);
        check_eq("rst_tag1", issue_rs1_tag, 0);
        check_eq("rst_tag2", issue_rs2_tag, 0);
        check_eq("rst_count", rob_count, 0);
    endtask

    function automatic bit [15:0] rand_word();
        bit [3:0] f;
        if ($urandom_range(7) == 0) f = 4'($urandom_range(15, 8));
        else f = 4'($urandom_range(7));
        return {f, 12'($urandom_range(4095))};
    endfunction

    bit [15:0] prog_init [9];
    bit        r_we;
    int        r_addr;
    bit [15:0] r_data;

    initial begin
        prog_init = '{16'h0123, 16'h2345, 16'h0456, 16'h1789, 16'h0abc,
                      16'h5127, 16'h6129, 16'hF000, 16'h0333};
        rst = 1'b1; prog_we = 1'b0; prog_addr = 5'd0; prog_data = 16'd0; pc = 5'd0;
        fetch_en = 1'b0; commit = 1'b0; rs_free = 1'b0; rs_free_unit = 2'd0; rs_free_slot = 2'd0;
        @(negedge clk1);
        do_reset();
        for (int a = 0; a < 32; a++)
            cycle(1'b1, a, (a < 9) ? prog_init[a] : rand_word(), 0, 1'b0, 1'b0, 1'b0, 0, 0);

        // First issue and dependent second issue.
        cycle(0, 0, 0, 0, 1, 0, 0, 0, 0);
        check_eq("a_ok", issue_ok, 1);
        check_eq("a_unit", issue_unit, 0);
        check_eq("a_rob", issue_rob, 0);
        check_eq("a_tag1", issue_rs1_tag, 0);
        cycle(0, 0, 0, 1, 1, 0, 0, 0, 0);
        check_eq("b_ok", issue_ok, 1);
        check_eq("b_unit", issue_unit, 1);
        check_eq("b_rob", issue_rob, 1);
        check_eq("b_tag_r3", issue_rs1_tag, 4'b1000);
        check_eq("b_count", rob_count, 1);
        // Fill the add/sub RS until the fourth add stalls, then free slot 1.
        cycle(0, 0, 0, 2, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 3, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 4, 1, 0, 0, 0, 0);
        check_eq("c_stall", stall, 1);
        cycle(0, 0, 0, 5, 1, 0, 0, 0, 0);
        check_eq("c_hold", inst, 16'h0abc);
        cycle(0, 0, 0, 0, 0, 0, 1, 0, 1);
        check_eq("c_ok", issue_ok, 1);
        check_eq("c_slot", issue_slot, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Store and branch issue without renaming; illegal opcode is dropped.
        do_reset();
        cycle(0, 0, 0, 5, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 6, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 7, 1, 0, 0, 0, 0);
        check_eq("d_count", rob_count, 2);
        check_eq("d_drop_ok", issue_ok, 0);
        check_eq("d_drop_stall", stall, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("d_count_after", rob_count, 2);

        // ROB full, then a commit lets the next writer of r3 wrap into ROB 0.
        do_reset();
        for (int k = 0; k < 12; k++) cycle(0, 0, 0, 8, 1, 0, 1, 0, k % 3);
        check_eq("e_full", rob_count, 8);
        check_eq("e_stall", stall, 1);
        cycle(0, 0, 0, 8, 1, 1, 1, 0, 0);
        check_eq("e_ok", issue_ok, 1);
        check_eq("e_rob_wrap", issue_rob, 0);
        check_eq("e_tag_r3", issue_rs1_tag, 4'hF);
        check_eq("e_count", rob_count, 7);
        cycle(0, 0, 0, 8, 1, 0, 0, 0, 0);
        check_eq("e_count_full", rob_count, 8);

        // Random traffic against the model, with occasional resets.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(199) == 0) begin
                do_reset();
            end else begin
                r_we   = ($urandom_range(7) == 0);
                r_addr = $urandom_range(31);
                r_data = rand_word();
                cycle(r_we, r_addr, r_data, $urandom_range(31), $urandom_range(9) < 7,
                      $urandom_range(9) < 3, $urandom_range(9) < 4, $urandom_range(3),
                      $urandom_range(3));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
